// File: rtl/reram_ctrl_pkg.sv
// Shared command/response formats for the ReRAM Wishbone slave and the program/verify sequencer.
package reram_ctrl_pkg;

  localparam int ROW_W  = 5;
  localparam int COL_W  = 5;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_ISSUE = 3'd1,
    S_WR_WAIT  = 3'd2,
    S_RD_ISSUE = 3'd3,
    S_RD_WAIT  = 3'd4,
    S_RESP     = 3'd5
  } state_e;

  typedef enum logic [1:0] {
    ST_OK          = 2'd0,
    ST_VERIFY_FAIL = 2'd1,
    ST_TIMEOUT     = 2'd2
  } status_e;

endpackage

// File: rtl/reram_prog_verify_ctrl.sv
// Single-cell command sequencer for the 32x32 ReRAM core: reads, and programs with
// write/read-back verify and bounded retries, one command outstanding at a time.
module reram_prog_verify_ctrl
  import reram_ctrl_pkg::*;
#(
  parameter int MAX_RETRY   = 3,
  parameter int TIMEOUT_CYC = 64,
  parameter int TOL         = 0
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              cfg_verify_en_i,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic              cmd_we_i,
  input  logic [ROW_W-1:0]  cmd_row_i,
  input  logic [COL_W-1:0]  cmd_col_i,
  input  logic [DATA_W-1:0] cmd_data_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic [1:0]        rsp_status_o,
  output logic [2:0]        rsp_retries_o,
  output logic              core_req_o,
  output logic              core_we_o,
  output logic [ROW_W-1:0]  core_row_o,
  output logic [COL_W-1:0]  core_col_o,
  output logic [DATA_W-1:0] core_wdata_o,
  input  logic              core_done_i,
  input  logic [DATA_W-1:0] core_rdata_i,
  output logic [15:0]       fail_cnt_o
);

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e              state_q, state_d;
  status_e             status_q, status_d;
  logic                retry_inc;
  logic                we_q, verify_q;
  logic [ROW_W-1:0]    row_q;
  logic [COL_W-1:0]    col_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [2:0]          retry_q;
  logic [7:0]          to_cnt_q;
  logic [15:0]         fail_cnt_q;
  logic                to_hit;

  function automatic logic within_tol(input logic [DATA_W-1:0] rb, input logic [DATA_W-1:0] tgt);
    logic [DATA_W:0] diff;
    logic [DATA_W:0] mag;
    diff = {1'b0, rb} - {1'b0, tgt};
    mag  = diff[DATA_W] ? -diff : diff;
    return int'(mag) <= TOL;
  endfunction

  assign to_hit = (to_cnt_q == TO_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    status_d  = status_q;
    retry_inc = 1'b0;
    case (state_q)
      S_IDLE:     if (cmd_valid_i) state_d = cmd_we_i ? S_WR_ISSUE : S_RD_ISSUE;
      S_WR_ISSUE: state_d = S_WR_WAIT;
      S_RD_ISSUE: state_d = S_RD_WAIT;
      S_WR_WAIT: begin
        if (core_done_i) begin
          if (verify_q) begin
            state_d = S_RD_ISSUE;
          end else begin
            state_d  = S_RESP;
            status_d = ST_OK;
          end
        end else if (to_hit) begin
          state_d  = S_RESP;
          status_d = ST_TIMEOUT;
        end
      end
      S_RD_WAIT: begin
        if (core_done_i) begin
          if (!we_q || within_tol(core_rdata_i, wdata_q)) begin
            state_d  = S_RESP;
            status_d = ST_OK;
          end else if (int'(retry_q) < MAX_RETRY) begin
            state_d   = S_WR_ISSUE;
            retry_inc = 1'b1;
          end else begin
            state_d  = S_RESP;
            status_d = ST_VERIFY_FAIL;
          end
        end else if (to_hit) begin
          state_d  = S_RESP;
          status_d = ST_TIMEOUT;
        end
      end
      S_RESP:     if (rsp_ready_i) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Ready is forced low while reset is held so every output reads 0 during reset.
  always_comb begin
    cmd_ready_o = wb_rst_i && (state_q == S_IDLE);
    core_req_o  = (state_q == S_WR_ISSUE) || (state_q == S_RD_ISSUE);
    core_we_o   = (state_q == S_WR_ISSUE);
    rsp_valid_o = (state_q == S_RESP);
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      we_q       <= 1'b0;
      verify_q   <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      retry_q    <= '0;
      to_cnt_q   <= '0;
      status_q   <= ST_OK;
      fail_cnt_q <= '0;
    end else begin
      if (state_q == S_IDLE && cmd_valid_i) begin
        we_q     <= cmd_we_i;
        verify_q <= cfg_verify_en_i;
        row_q    <= cmd_row_i;
        col_q    <= cmd_col_i;
        wdata_q  <= cmd_data_i;
        rdata_q  <= '0;
        retry_q  <= '0;
      end
      if (state_q == S_RD_WAIT && core_done_i) rdata_q <= core_rdata_i;
      if (retry_inc) retry_q <= retry_q + 3'd1;
      // Counter runs from the issue cycle so the timeout lands TIMEOUT_CYC cycles after the strobe.
      if (state_d == S_WR_ISSUE || state_d == S_RD_ISSUE)
        to_cnt_q <= '0;
      else if (state_q != S_IDLE && state_q != S_RESP)
        to_cnt_q <= to_cnt_q + 8'd1;
      if (state_q != S_RESP && state_d == S_RESP) begin
        status_q <= status_d;
        if (status_d != ST_OK && fail_cnt_q != 16'hFFFF) fail_cnt_q <= fail_cnt_q + 16'd1;
      end
    end
  end

  assign rsp_data_o    = rdata_q;
  assign rsp_status_o  = status_q;
  assign rsp_retries_o = retry_q;
  assign core_row_o    = row_q;
  assign core_col_o    = col_q;
  assign core_wdata_o  = wdata_q;
  assign fail_cnt_o    = fail_cnt_q;

endmodule
